// File: rtl/sym_vn_lut_write_ctrl.sv
// Write-side controller for the symmetric 2-input VN IB-LUT RAM.
// Pairs streamed entries into bank0/bank1 words and writes one page per pair.
module sym_vn_lut_write_ctrl #(
  parameter int QUAN_SIZE       = 3,
  parameter int LUT_PORT_SIZE   = 3,
  parameter int ENTRY_ADDR      = 5,
  parameter int MULTI_FRAME_NUM = 2,
  localparam int PAGE_W = ENTRY_ADDR - $clog2(MULTI_FRAME_NUM)
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start,
  input  logic                     load_offset,
  input  logic [LUT_PORT_SIZE-1:0] entry_in,
  input  logic                     entry_valid,
  output logic                     entry_ready,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
  output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
  output logic [PAGE_W-1:0]        page_write_addr,
  output logic                     write_addr_offset,
  output logic                     we,
  output logic                     busy,
  output logic                     load_done
);

  localparam logic [PAGE_W-1:0] PAGE_LAST = '1;

  if (QUAN_SIZE < 1 || LUT_PORT_SIZE < 1) begin : g_bad_width
    $error("sym_vn_lut_write_ctrl: widths must be positive");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [PAGE_W-1:0]        r_page;
  logic [LUT_PORT_SIZE-1:0] r_bank0;
  logic [LUT_PORT_SIZE-1:0] r_bank1;
  logic                     r_offset;
  logic                     w_hs;

  assign entry_ready = (r_state == S_FETCH0) |
                       (r_state == S_FETCH1);
  assign w_hs        = entry_valid & entry_ready;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (load_start) w_next = S_FETCH0;
      S_FETCH0: if (w_hs) w_next = S_FETCH1;
      S_FETCH1: if (w_hs) w_next = S_WRITE;
      S_WRITE:
        if (r_page == PAGE_LAST) w_next = S_DONE;
        else                     w_next = S_FETCH0;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_page   <= '0;
      r_bank0  <= '0;
      r_bank1  <= '0;
      r_offset <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && load_start) begin
        r_offset <= load_offset;
        r_page   <= '0;
      end
      if (r_state == S_FETCH0 && w_hs) r_bank0 <= entry_in;
      if (r_state == S_FETCH1 && w_hs) r_bank1 <= entry_in;
      // counter parks on the last page so the address holds through DONE
      if (r_state == S_WRITE && r_page != PAGE_LAST)
        r_page <= r_page + 1'b1;
    end
  end

  assign lut_in_bank0      = r_bank0;
  assign lut_in_bank1      = r_bank1;
  assign page_write_addr   = r_page;
  assign write_addr_offset = r_offset;
  assign we                = (r_state == S_WRITE);
  assign busy              = (r_state != S_IDLE);
  assign load_done         = (r_state == S_DONE);

endmodule
